// File: rtl/fp_to_int_conv_if.sv
// Start/busy/done handshake bundle for the float-to-integer converter.
// Ports: start, a (request); busy, done, data_out, status_out (response).
interface fp_to_int_conv_if;
    logic        start;
    logic [31:0] a;
    logic        busy;
    logic        done;
    logic [31:0] data_out;
    logic [3:0]  status_out;

    // Requester drives start/a and watches the response.
    modport master (
        output start,
        output a,
        input  busy,
        input  done,
        input  data_out,
        input  status_out
    );

    // Converter side.
    modport slave (
        input  start,
        input  a,
        output busy,
        output done,
        output data_out,
        output status_out
    );
endinterface

// File: rtl/fp_to_int_conv.sv
// Multi-cycle conversion of a bias-63 float to a signed 32-bit integer.
// Ports: clk, reset (async, active-high), bus (slave: start/a in;
// busy/done/data_out/status_out out). Status one-hot EXACT/INEXACT/OVF/UNF.
module fp_to_int_conv #(
    parameter int BIAS    = 63,
    parameter int MAX_RSH = 26
) (
    input  logic              clk,
    input  logic              reset,
    fp_to_int_conv_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        SHIFT,
        ROUND,
        DONE
    } state_t;

    localparam logic [3:0] ST_EXACT = 4'b0001;
    localparam logic [3:0] ST_INEXACT = 4'b0010;
    localparam logic [3:0] ST_OVF = 4'b0100;
    localparam logic [3:0] ST_UNF = 4'b1000;

    // Exponent at which mant25 already is the integer value (k == 0).
    localparam logic [6:0] KOFF = 7'(BIAS + 24);
    // Smallest exponent whose magnitude no longer fits 31 bits.
    localparam logic [6:0] OVF_E = 7'(BIAS + 31);
    localparam logic [6:0] RCAP = 7'(MAX_RSH);

    state_t      state;
    logic        sign;
    logic [6:0]  exp_r;
    logic [23:0] frac_r;
    logic [31:0] acc;
    logic        guard;
    logic        sticky;
    logic [4:0]  cnt;
    logic        left;
    logic [31:0] res;
    logic [3:0]  st;

    logic        go_left;
    logic [6:0]  lsh;
    logic [6:0]  rsh;
    logic [4:0]  rcnt;
    logic        inc;
    logic [31:0] mag;

    always_comb begin
        go_left = exp_r > KOFF;
        lsh     = exp_r - KOFF;
        rsh     = KOFF - exp_r;
        // Past MAX_RSH steps every mantissa bit is already sticky.
        rcnt    = (rsh > RCAP) ? RCAP[4:0] : rsh[4:0];
        // Round to nearest, ties to even.
        inc     = guard & (sticky | acc[0]);
        mag     = acc + {31'b0, inc};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            sign           <= 1'b0;
            exp_r          <= '0;
            frac_r         <= '0;
            acc            <= '0;
            guard          <= 1'b0;
            sticky         <= 1'b0;
            cnt            <= '0;
            left           <= 1'b0;
            res            <= '0;
            st             <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.data_out   <= '0;
            bus.status_out <= '0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        sign     <= bus.a[31];
                        exp_r    <= bus.a[30:24];
                        frac_r   <= bus.a[23:0];
                        bus.busy <= 1'b1;
                        state    <= UNPACK;
                    end
                end
                UNPACK: begin
                    if (exp_r == 7'd0) begin
                        res   <= '0;
                        st    <= (frac_r == 24'd0) ? ST_EXACT : ST_UNF;
                        state <= DONE;
                    end else if (exp_r >= OVF_E) begin
                        // -2^31 is the one representable value here.
                        if (sign && exp_r == OVF_E && frac_r == 24'd0) begin
                            res <= 32'h8000_0000;
                            st  <= ST_EXACT;
                        end else begin
                            res <= '0;
                            st  <= ST_OVF;
                        end
                        state <= DONE;
                    end else begin
                        acc    <= {7'b0, 1'b1, frac_r};
                        guard  <= 1'b0;
                        sticky <= 1'b0;
                        left   <= go_left;
                        cnt    <= go_left ? lsh[4:0] : rcnt;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt != 5'd0) begin
                        cnt <= cnt - 5'd1;
                        if (left) begin
                            acc <= acc << 1;
                        end else begin
                            {acc, guard} <= {1'b0, acc};
                            sticky       <= sticky | guard;
                        end
                    end
                    if (cnt <= 5'd1) begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    if (mag == 32'd0) begin
                        res <= '0;
                        st  <= ST_UNF;
                    end else begin
                        res <= sign ? (~mag + 32'd1) : mag;
                        st  <= (guard | sticky) ? ST_INEXACT : ST_EXACT;
                    end
                    state <= DONE;
                end
                DONE: begin
                    bus.data_out   <= res;
                    bus.status_out <= st;
                    bus.done       <= 1'b1;
                    bus.busy       <= 1'b0;
                    state          <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
